power_switch_sequencer: RTL and testbench

POWER_SWITCH_SEQUENCER -- requirements
Module: power_switch_sequencer

---
 rtl/power_switch_sequencer.sv | 158 +++++++++++++++
 tb/tb_power_switch_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/power_switch_sequencer.sv
// Power-switch sequencer for a switchable domain: staged switch enables on wake,
// isolation / retention / clock-gate ordering on sleep, sticky timeout on missing ack.
module power_switch_sequencer #(
    parameter int N_STAGES    = 4,
    parameter int STAGE_DLY   = 8,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sleep_req,
    input  logic                sw_ack,
    output logic [N_STAGES-1:0] sleep_n,
    output logic                iso_en,
    output logic                save,
    output logic                restore,
    output logic                clk_en,
    output logic                domain_on,
    output logic                err
);

    // state     | meaning
    // ----------+------------------------------------------------------------
    // OFF       | all stages off, isolated, clock gated; waits for wake
    // WAKE      | stages enabled one by one, STAGE_DLY cycles apart
    // WAIT_ACK  | all stages on, waiting for power-good (bounded)
    // RESTORE   | one-cycle retention restore strobe, still isolated
    // ON        | domain powered, un-isolated, clocked
    // CLK_STOP  | clock gated first on the way down
    // ISO       | isolation clamps applied
    // SAVE      | one-cycle retention save strobe
    // SHUTDOWN  | all stages switched off together
    typedef enum logic [3:0] {
        S_OFF,
        S_WAKE,
        S_WAIT_ACK,
        S_RESTORE,
        S_ON,
        S_CLK_STOP,
        S_ISO,
        S_SAVE,
        S_SHUTDOWN
    } state_t;

    localparam int DW = $clog2(STAGE_DLY + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [DW-1:0] DLY_LAST = DW'(STAGE_DLY - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [N_STAGES-1:0] FIRST_STAGE = N_STAGES'(1);
    localparam logic [N_STAGES-1:0] ALL_STAGES  = {N_STAGES{1'b1}};

    state_t        state;
    logic [DW-1:0] dly_cnt;
    logic [TW-1:0] to_cnt;
    logic          wake_blk;

    // Outputs are assigned together with the state they belong to, so every
    // output reflects the state register on the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_OFF;
            sleep_n   <= '0;
            iso_en    <= 1'b1;
            save      <= 1'b0;
            restore   <= 1'b0;
            clk_en    <= 1'b0;
            domain_on <= 1'b0;
            err       <= 1'b0;
            wake_blk  <= 1'b0;
            dly_cnt   <= '0;
            to_cnt    <= '0;
        end else begin
            save    <= 1'b0;
            restore <= 1'b0;
            dly_cnt <= '0;
            to_cnt  <= '0;
            case (state)
                S_OFF: begin
                    if (sleep_req) begin
                        wake_blk <= 1'b0;
                    end else if (!wake_blk) begin
                        state   <= S_WAKE;
                        sleep_n <= FIRST_STAGE;
                    end
                end
                S_WAKE: begin
                    if (sleep_req) begin
                        state   <= S_OFF;
                        sleep_n <= '0;
                    end else if (dly_cnt == DLY_LAST) begin
                        if (sleep_n[N_STAGES-1]) begin
                            state <= S_WAIT_ACK;
                        end else begin
                            sleep_n <= (sleep_n << 1) | FIRST_STAGE;
                        end
                    end else begin
                        dly_cnt <= dly_cnt + DW'(1);
                    end
                end
                S_WAIT_ACK: begin
                    if (sleep_req) begin
                        state   <= S_OFF;
                        sleep_n <= '0;
                    end else if (sw_ack) begin
                        state   <= S_RESTORE;
                        restore <= 1'b1;
                    end else if (to_cnt == TO_LAST) begin
                        state    <= S_OFF;
                        sleep_n  <= '0;
                        err      <= 1'b1;
                        wake_blk <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                S_RESTORE: begin
                    state     <= S_ON;
                    iso_en    <= 1'b0;
                    clk_en    <= 1'b1;
                    domain_on <= 1'b1;
                end
                S_ON: begin
                    if (sleep_req) begin
                        state     <= S_CLK_STOP;
                        clk_en    <= 1'b0;
                        domain_on <= 1'b0;
                    end
                end
                S_CLK_STOP: begin
                    state  <= S_ISO;
                    iso_en <= 1'b1;
                end
                S_ISO: begin
                    state <= S_SAVE;
                    save  <= 1'b1;
                end
                S_SAVE: begin
                    state   <= S_SHUTDOWN;
                    sleep_n <= '0;
                end
                S_SHUTDOWN: begin
                    state <= S_OFF;
                end
                default: begin
                    state     <= S_OFF;
                    sleep_n   <= '0;
                    iso_en    <= 1'b1;
                    clk_en    <= 1'b0;
                    domain_on <= 1'b0;
                end
            endcase
        end
    end

    // Keeps the full-on pattern referenced for readers checking ON-state values.
    logic unused_all_on;
    assign unused_all_on = &ALL_STAGES;

endmodule

// File: tb/tb_power_switch_sequencer.sv
// Randomized scenario bench: each scenario's output events (value + cycle) are
// derived from the sequencing rules up front and checked by an independent monitor.
module tb_power_switch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sleep_req;
    logic       sw_ack;
    logic [3:0] sleep_n;
    logic       iso_en, save, restore, clk_en, domain_on, err;

    power_switch_sequencer #(.N_STAGES(4), .STAGE_DLY(8), .ACK_TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .sleep_req(sleep_req), .sw_ack(sw_ack),
        .sleep_n(sleep_n), .iso_en(iso_en), .save(save), .restore(restore),
        .clk_en(clk_en), .domain_on(domain_on), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [9:0] v;
    } ev_t;
    ev_t exp_q[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    bit   rchk = 1'b0;
    logic [9:0] prev_v;
    logic [9:0] cur_v;
    assign cur_v = {sleep_n, iso_en, save, restore, clk_en, domain_on, err};

    function automatic logic [9:0] mk(logic [3:0] sn, bit iso, bit sv, bit rs, bit ck, bit dm, bit er);
        return {sn, iso, sv, rs, ck, dm, er};
    endfunction

    // Monitor: reset snapshot check on rchk, otherwise compare each output change
    // against the next expected event, and flag expected events that never came.
    always @(negedge clk or posedge rchk) begin
        ev_t ev;
        if (rchk) begin
            n_cmp++;
            if (cur_v !== mk(4'b0000, 1, 0, 0, 0, 0, 0)) begin
                n_bad++;
                $display("FAIL reset_values t=%0t got=%b want=%b", $time, cur_v, mk(4'b0000, 1, 0, 0, 0, 0, 0));
            end
            prev_v = cur_v;
        end else if (!mon_en) begin
            prev_v = cur_v;
        end else begin
            if (cur_v !== prev_v) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change cyc=%0d got=%b want=no change", cyc, cur_v);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.cyc != cyc || ev.v !== cur_v) begin
                        n_bad++;
                        $display("FAIL out_event got=%b@%0d want=%b@%0d", cur_v, cyc, ev.v, ev.cyc);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                ev = exp_q.pop_front();
                $display("FAIL missed_event cyc=%0d got=%b want=%b@%0d", cyc, cur_v, ev.v, ev.cyc);
            end
            prev_v = cur_v;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    // Scenario parameters (absolute posedge numbers at which inputs are sampled)
    int w, a, r, q, s, e, lim, kind;
    bit has_a, has_r, rewake, aborted, on_path, tmo, err_m;

    function automatic bit req_at(int p);
        if (aborted) return p >= r;
        if (on_path) begin
            if (has_r) return p >= r;
            return (p >= s) && !(rewake && p >= s + 1 && p <= s + 5);
        end
        return (p >= w + 106) || (has_r && p >= r);
    endfunction

    function automatic bit ack_at(int p);
        return has_a && p >= a;
    endfunction

    task automatic push(int c, logic [9:0] v);
        exp_q.push_back('{c, v});
    endtask

    task automatic run_scenario(int idx);
        logic [3:0] thermo;
        w = cyc + 1;
        kind = (idx < 3) ? idx : int'($urandom_range(0, 3));
        has_a = 0; has_r = 0; rewake = 0; a = 0; r = 0;
        case (kind)
            0: begin
                has_a = 1;
                a = (idx == 0) ? w : w + int'($urandom_range(0, 60));
                rewake = (idx == 0) ? 1'b0 : bit'($urandom_range(0, 1));
            end
            1: ;
            2: begin
                has_r = 1;
                r = (idx == 2) ? w + 9 : w + 1 + int'($urandom_range(0, 95));
                has_a = bit'($urandom_range(0, 1));
                a = w + int'($urandom_range(0, 110));
            end
            default: begin
                has_a = ($urandom_range(0, 3) != 0);
                a = w + int'($urandom_range(0, 110));
                has_r = bit'($urandom_range(0, 1));
                r = w + 1 + int'($urandom_range(0, 109));
                rewake = bit'($urandom_range(0, 1));
            end
        endcase
        q = has_a ? ((a > w + 33) ? a : w + 33) : 32'h4000_0000;
        lim = (q < w + 96) ? q : w + 96;
        aborted = has_r && (r <= lim);
        on_path = !aborted && has_a && (q <= w + 96);
        tmo = !aborted && !on_path;
        if (!on_path || has_r) rewake = 0;
        if (on_path) s = has_r ? ((r > q + 2) ? r : q + 2) : q + 2 + int'($urandom_range(0, 10));

        // Thermometer wake: stage k conducts 8*k cycles after the first.
        thermo = 4'b0001;
        push(w, mk(thermo, 1, 0, 0, 0, 0, err_m));
        for (int k = 1; k < 4; k++) begin
            thermo = {thermo[2:0], 1'b1};
            if (!(aborted && w + 8 * k >= r)) push(w + 8 * k, mk(thermo, 1, 0, 0, 0, 0, err_m));
        end
        if (aborted) begin
            push(r, mk(4'b0000, 1, 0, 0, 0, 0, err_m));
            e = r + 3;
        end else if (on_path) begin
            push(q,     mk(4'b1111, 1, 0, 1, 0, 0, err_m));
            push(q + 1, mk(4'b1111, 0, 0, 0, 1, 1, err_m));
            push(s,     mk(4'b1111, 0, 0, 0, 0, 0, err_m));
            push(s + 1, mk(4'b1111, 1, 0, 0, 0, 0, err_m));
            push(s + 2, mk(4'b1111, 1, 1, 0, 0, 0, err_m));
            push(s + 3, mk(4'b0000, 1, 0, 0, 0, 0, err_m));
            if (rewake) begin
                push(s + 5, mk(4'b0001, 1, 0, 0, 0, 0, err_m));
                push(s + 6, mk(4'b0000, 1, 0, 0, 0, 0, err_m));
                e = s + 9;
            end else begin
                e = s + 6;
            end
        end else begin
            err_m = 1;
            push(w + 96, mk(4'b0000, 1, 0, 0, 0, 0, 1));
            e = w + 110;
        end

        for (int p = w; p <= e; p++) begin
            sleep_req = req_at(p);
            sw_ack = ack_at(p);
            @(negedge clk);
        end
        sleep_req = 1'b1;
        sw_ack = 1'b0;
        repeat ($urandom_range(2, 5)) @(negedge clk);
    endtask

    initial begin
        int c2;
        err_m = 0;
        rst_n = 1'b1;
        sleep_req = 1'b1;
        sw_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1 rchk = 1'b1;
        #1 rchk = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 24; i++) run_scenario(i);

        // Power up to ON, then asynchronous reset in the middle of a cycle.
        w = cyc + 1;
        sleep_req = 1'b0;
        sw_ack = 1'b1;
        push(w,      mk(4'b0001, 1, 0, 0, 0, 0, err_m));
        push(w + 8,  mk(4'b0011, 1, 0, 0, 0, 0, err_m));
        push(w + 16, mk(4'b0111, 1, 0, 0, 0, 0, err_m));
        push(w + 24, mk(4'b1111, 1, 0, 0, 0, 0, err_m));
        push(w + 33, mk(4'b1111, 1, 0, 1, 0, 0, err_m));
        push(w + 34, mk(4'b1111, 0, 0, 0, 1, 1, err_m));
        while (cyc < w + 40) @(negedge clk);
        mon_en = 1'b0;
        sw_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1 rchk = 1'b1;
        #1 rchk = 1'b0;
        err_m = 0;
        repeat (2) @(negedge clk);
        c2 = cyc;
        push(c2 + 1, mk(4'b0001, 1, 0, 0, 0, 0, 0));
        push(c2 + 2, mk(4'b0000, 1, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        sleep_req = 1'b1;
        repeat (6) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
